delay_arbiter: RTL

- Round-robin scheduler that shares one millisecond delay timer among N requesters (game FSM, sound, LED blink, input debounce).
- Each requester asks for a 0..255 ms wait. The arbiter grants the timer, loads it, watches its free flag, and returns a one-cycle done pulse to the winner.
- Sits between the requesters and a single instance of the `delay` timer. It drives the timer's set, ms and rst inputs and reads its free output.

---
 rtl/delay_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/delay_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// Shared types and constants for the millisecond delay timer
// and the arbiter that shares it among requesters.
package delay_pkg;

    localparam int MS_W         = 8;
    localparam int TICKS_PER_MS = 10000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT,
        DONE,
        CANCEL
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request bit at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             s;

    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    // lowest rotation offset wins; scan high to low so it lands last
    always_comb begin
        found = 1'b0;
        idx   = '0;
        s     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                s     = int'(ptr) + i;
                if (s >= N) s = s - N;
                idx   = IDX_W'(s);
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of the single ms delay timer: grants, loads,
// watches free, and pulses done (or aborts the timer on withdrawal).
module delay_arbiter
    import delay_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [MS_W*N-1:0] req_ms,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic              busy,
    output logic              tmr_set,
    output logic [MS_W-1:0]   tmr_ms,
    output logic              tmr_rst,
    input  logic              tmr_free
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             abort;

    rr_pick #(
        .N    (N),
        .IDX_W(IDX_W)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    assign idx_next = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);

    // a withdrawn request beats a same-cycle timer expiry
    assign abort = ~req[idx] & (state inside {LOAD, ARM, WAIT});

    // FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            tmr_ms  <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            tmr_set <= 1'b0;
            tmr_rst <= 1'b0;
        end else begin
            tmr_set <= 1'b0;
            tmr_rst <= 1'b0;
            done    <= '0;
            if (abort) begin
                state   <= CANCEL;
                tmr_rst <= 1'b1;
                grant   <= '0;
                ptr     <= idx_next;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (pick_found) begin
                            state   <= LOAD;
                            idx     <= pick_idx;
                            tmr_ms  <= req_ms[MS_W*int'(pick_idx) +: MS_W];
                            grant   <= N'(1) << pick_idx;
                            busy    <= 1'b1;
                            tmr_set <= 1'b1;
                        end
                    end
                    LOAD: state <= ARM;
                    ARM:  state <= WAIT;
                    WAIT: begin
                        if (tmr_free) begin
                            state <= DONE;
                            done  <= N'(1) << idx;
                            grant <= '0;
                            ptr   <= idx_next;
                        end
                    end
                    DONE, CANCEL: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        grant <= '0;
                    end
                endcase
            end
        end
    end

endmodule
